axi4_sha_master: RTL and testbench

//  AXI4-Lite initiator that drives the memory-mapped SHA-256 peripheral without CPU involvement. On start it

---
 rtl/axi4_sha_master.sv | 184 ++++++++++++++++++
 tb/tb_axi4_sha_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sha_master.sv
// rtl/axi4_sha_master.sv - AXI4-Lite initiator that loads one block into the SHA-256 peripheral,
// polls its ready flag and reads the 256-bit digest back.
module axi4_sha_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [511:0] msg_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [255:0] hash_out,
  output logic         mem_axi_awvalid,
  input  logic         mem_axi_awready,
  output logic [31:0]  mem_axi_awaddr,
  output logic [2:0]   mem_axi_awprot,
  output logic         mem_axi_wvalid,
  input  logic         mem_axi_wready,
  output logic [31:0]  mem_axi_wdata,
  output logic [3:0]   mem_axi_wstrb,
  input  logic         mem_axi_bvalid,
  output logic         mem_axi_bready,
  output logic         mem_axi_arvalid,
  input  logic         mem_axi_arready,
  output logic [31:0]  mem_axi_araddr,
  output logic [2:0]   mem_axi_arprot,
  input  logic         mem_axi_rvalid,
  output logic         mem_axi_rready,
  input  logic [31:0]  mem_axi_rdata
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_FIN} state_t;
  typedef enum logic [2:0] {P_RST_ON, P_MSG, P_RST_OFF, P_POLL, P_HASH} phase_t;

  state_t         state, state_nxt;
  phase_t         phase;
  logic [3:0]     idx;
  logic [PW-1:0]  poll_cnt;
  logic [511:0]   msg_q;
  logic           aw_pend, w_pend;
  logic           wr_acc, poll_last;
  logic [31:0]    msg_word;

  // A channel counts as finished once its own handshake has happened, now or earlier.
  assign wr_acc    = (!aw_pend || mem_axi_awready) && (!w_pend || mem_axi_wready);
  assign poll_last = (poll_cnt == PW'(POLL_LIMIT - 1));
  assign msg_word  = msg_q[{~idx, 5'b0} +: 32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_WR;
      S_WR:      if (wr_acc) state_nxt = S_WR_RESP;
      S_WR_RESP: if (mem_axi_bvalid) state_nxt = (phase == P_RST_OFF) ? S_RD : S_WR;
      S_RD:      if (mem_axi_arready) state_nxt = S_RD_DATA;
      S_RD_DATA: begin
        if (mem_axi_rvalid) begin
          if (phase == P_POLL) begin
            state_nxt = (!mem_axi_rdata[0] && poll_last) ? S_FIN : S_RD;
          end else begin
            state_nxt = (idx == 4'd7) ? S_FIN : S_RD;
          end
        end
      end
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase    <= P_RST_ON;
      idx      <= 4'd0;
      poll_cnt <= '0;
      msg_q    <= '0;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      error    <= 1'b0;
      hash_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            msg_q    <= msg_in;
            hash_out <= '0;
            error    <= 1'b0;
            phase    <= P_RST_ON;
            idx      <= 4'd0;
            poll_cnt <= '0;
            aw_pend  <= 1'b1;
            w_pend   <= 1'b1;
          end
        end
        S_WR: begin
          if (mem_axi_awready) aw_pend <= 1'b0;
          if (mem_axi_wready)  w_pend  <= 1'b0;
        end
        S_WR_RESP: begin
          if (mem_axi_bvalid) begin
            case (phase)
              P_RST_ON: begin
                phase   <= P_MSG;
                idx     <= 4'd0;
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
              end
              P_MSG: begin
                if (idx == 4'd15) begin
                  phase <= P_RST_OFF;
                  idx   <= 4'd0;
                end else begin
                  idx <= idx + 4'd1;
                end
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
              end
              default: begin
                phase    <= P_POLL;
                poll_cnt <= '0;
              end
            endcase
          end
        end
        S_RD_DATA: begin
          if (mem_axi_rvalid) begin
            if (phase == P_POLL) begin
              if (mem_axi_rdata[0]) begin
                phase <= P_HASH;
                idx   <= 4'd0;
              end else if (poll_last) begin
                error <= 1'b1;
              end else begin
                poll_cnt <= poll_cnt + PW'(1);
              end
            end else begin
              hash_out[{~idx[2:0], 5'b0} +: 32] <= mem_axi_rdata;
              idx <= idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_axi_awaddr = BASE_ADDR;
    mem_axi_wdata  = 32'd0;
    case (phase)
      P_RST_ON: mem_axi_wdata = 32'd1;
      P_MSG: begin
        mem_axi_awaddr = BASE_ADDR + 32'h100 + {26'd0, idx, 2'b00};
        mem_axi_wdata  = msg_word;
      end
      default: ;
    endcase
  end

  assign mem_axi_araddr  = (phase == P_HASH) ? BASE_ADDR + 32'h200 + {27'd0, idx[2:0], 2'b00}
                                             : BASE_ADDR;
  assign mem_axi_awvalid = aw_pend;
  assign mem_axi_wvalid  = w_pend;
  assign mem_axi_bready  = (state == S_WR_RESP);
  assign mem_axi_arvalid = (state == S_RD);
  assign mem_axi_rready  = (state == S_RD_DATA);
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_arprot  = 3'b000;
  assign mem_axi_wstrb   = 4'hF;
  assign busy            = (state != S_IDLE) && (state != S_FIN);
  assign done            = (state == S_FIN);

endmodule

// File: tb/tb_axi4_sha_master.sv
// tb/tb_axi4_sha_master.sv - bench for axi4_sha_master with a behavioural SHA-256 peripheral
// that stalls randomly and computes the real digest of whatever block it was sent.
module tb_axi4_sha_master;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          PLIM = 40;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk, resetn, start;
  logic [511:0] msg_in;
  logic         busy, done, error;
  logic [255:0] hash_out;
  logic         mem_axi_awvalid, mem_axi_awready, mem_axi_wvalid, mem_axi_wready;
  logic         mem_axi_bvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_arready;
  logic         mem_axi_rvalid, mem_axi_rready;
  logic [31:0]  mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_rdata;
  logic [2:0]   mem_axi_awprot, mem_axi_arprot;
  logic [3:0]   mem_axi_wstrb;

  axi4_sha_master #(.BASE_ADDR(BASE), .POLL_LIMIT(PLIM)) dut (
    .clk(clk), .resetn(resetn), .start(start), .msg_in(msg_in),
    .busy(busy), .done(done), .error(error), .hash_out(hash_out),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_block(input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  // Peripheral model state, shared with the main sequence through these variables.
  int           stall_wr = 0, stall_rsp = 0, ready_after = 0;
  int           proto_err = 0, done_cnt = 0;
  logic [31:0]  wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  logic [31:0]  mem_msg [16];
  logic [255:0] core_digest;
  bit           released;
  int           ctrl_reads;
  bit           hs_aw, hs_w, hs_b, hs_ar, hs_r;
  bit           got_aw, got_w, got_ar;
  bit           aw_arm, w_arm, b_arm, ar_arm, r_arm;
  int           aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0]  aw_snap, w_snap, ar_snap, aw_addr_h, w_data_h, r_val, tmp;
  bit           p_awvalid, p_wvalid, p_arvalid;
  logic [31:0]  p_awaddr, p_wdata, p_araddr;
  logic [511:0] blk;

  // Responder: everything happens on the falling edge, handshakes are the ones the
  // rising edge in between will see.
  initial begin
    {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid} = '0;
    mem_axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid} = '0;
        {hs_aw, hs_w, hs_b, hs_ar, hs_r, got_aw, got_w, got_ar} = '0;
        {aw_arm, w_arm, b_arm, ar_arm, r_arm, p_awvalid, p_wvalid, p_arvalid} = '0;
        released = 0;
        ctrl_reads = 0;
        continue;
      end
      if (p_awvalid && !hs_aw && !(mem_axi_awvalid && mem_axi_awaddr == p_awaddr)) proto_err++;
      if (p_wvalid && !hs_w && !(mem_axi_wvalid && mem_axi_wdata == p_wdata)) proto_err++;
      if (p_arvalid && !hs_ar && !(mem_axi_arvalid && mem_axi_araddr == p_araddr)) proto_err++;
      if ((mem_axi_awvalid || mem_axi_wvalid) && mem_axi_arvalid) proto_err++;
      if ((mem_axi_awvalid && mem_axi_awprot != 3'b000) || (mem_axi_wvalid && mem_axi_wstrb != 4'hF) ||
          (mem_axi_arvalid && mem_axi_arprot != 3'b000)) proto_err++;
      if (done && busy) proto_err++;
      if (done) done_cnt++;

      if (hs_aw) begin if (got_aw) proto_err++; got_aw = 1; aw_addr_h = aw_snap; end
      if (hs_w)  begin if (got_w)  proto_err++; got_w  = 1; w_data_h  = w_snap;  end
      if (hs_b) begin
        wr_addr_q.push_back(aw_addr_h);
        wr_data_q.push_back(w_data_h);
        if (aw_addr_h == BASE) begin
          released   = (w_data_h[0] == 1'b0);
          ctrl_reads = 0;
          for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = mem_msg[i];
          core_digest = sha256_block(blk);
        end else if (aw_addr_h >= BASE + 32'h100 && aw_addr_h < BASE + 32'h140) begin
          mem_msg[(aw_addr_h - BASE - 32'h100) >> 2] = w_data_h;
        end
        got_aw = 0; got_w = 0; mem_axi_bvalid = 0;
      end
      if (hs_ar) begin
        if (got_ar) proto_err++;
        got_ar = 1;
        rd_addr_q.push_back(ar_snap);
        tmp = $urandom;
        if (ar_snap == BASE) begin
          r_val = {tmp[31:1], (released && ctrl_reads >= ready_after) ? 1'b1 : 1'b0};
          ctrl_reads++;
        end else if (ar_snap >= BASE + 32'h200 && ar_snap < BASE + 32'h220) begin
          r_val = core_digest[255 - 32*int'((ar_snap - BASE - 32'h200) >> 2) -: 32];
        end else begin
          r_val = tmp;
        end
      end
      if (hs_r) begin got_ar = 0; mem_axi_rvalid = 0; end

      mem_axi_awready = 0;
      if (mem_axi_awvalid) begin
        if (!aw_arm) begin aw_arm = 1; aw_cnt = $urandom_range(stall_wr, 0); end
        if (aw_cnt == 0) begin mem_axi_awready = 1; aw_arm = 0; end else aw_cnt--;
      end
      mem_axi_wready = 0;
      if (mem_axi_wvalid) begin
        if (!w_arm) begin w_arm = 1; w_cnt = $urandom_range(stall_wr, 0); end
        if (w_cnt == 0) begin mem_axi_wready = 1; w_arm = 0; end else w_cnt--;
      end
      if (got_aw && got_w && !mem_axi_bvalid) begin
        if (!b_arm) begin b_arm = 1; b_cnt = $urandom_range(stall_rsp, 0); end
        if (b_cnt == 0) begin mem_axi_bvalid = 1; b_arm = 0; end else b_cnt--;
      end
      mem_axi_arready = 0;
      if (mem_axi_arvalid) begin
        if (!ar_arm) begin ar_arm = 1; ar_cnt = $urandom_range(stall_rsp, 0); end
        if (ar_cnt == 0) begin mem_axi_arready = 1; ar_arm = 0; end else ar_cnt--;
      end
      if (got_ar && !mem_axi_rvalid) begin
        if (!r_arm) begin r_arm = 1; r_cnt = $urandom_range(stall_rsp, 0); end
        if (r_cnt == 0) begin mem_axi_rvalid = 1; mem_axi_rdata = r_val; r_arm = 0; end else r_cnt--;
      end
      if (!mem_axi_rvalid) mem_axi_rdata = $urandom;

      hs_aw = mem_axi_awvalid && mem_axi_awready; aw_snap = mem_axi_awaddr;
      hs_w  = mem_axi_wvalid && mem_axi_wready;   w_snap  = mem_axi_wdata;
      hs_b  = mem_axi_bvalid && mem_axi_bready;
      hs_ar = mem_axi_arvalid && mem_axi_arready; ar_snap = mem_axi_araddr;
      hs_r  = mem_axi_rvalid && mem_axi_rready;
      p_awvalid = mem_axi_awvalid; p_awaddr = mem_axi_awaddr;
      p_wvalid  = mem_axi_wvalid;  p_wdata  = mem_axi_wdata;
      p_arvalid = mem_axi_arvalid; p_araddr = mem_axi_araddr;
    end
  end

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  task automatic run_job(input logic [511:0] msg, input int ra, input bit disturb);
    int cyc, n_ctrl, n_reads;
    bit succ, got_done, zero_wait;
    logic [31:0] ea, ed;
    zero_wait = (stall_wr == 0) && (stall_rsp == 0);
    succ      = (ra < PLIM);
    n_ctrl    = succ ? ra + 1 : PLIM;
    n_reads   = n_ctrl + (succ ? 8 : 0);
    @(negedge clk);
    ready_after = ra;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    done_cnt = 0; proto_err = 0;
    msg_in = msg;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check("busy_after_start", 256'(busy), 256'(1));
    check("error_cleared_on_start", 256'(error), 256'(0));
    check("hash_cleared_on_start", hash_out, 256'(0));
    if (disturb) msg_in = ~msg;
    got_done = done;
    while (!got_done && cyc < 3000) begin
      start = disturb && (cyc % 13 == 0);
      if (start) msg_in = rand_msg();
      @(negedge clk);
      cyc++;
      got_done = done;
    end
    start = 1'b0;
    check("done_seen_in_budget", 256'(got_done), 256'(1));
    check("busy_low_with_done", 256'(busy), 256'(0));
    if (zero_wait) check("zero_wait_latency", 256'(cyc), 256'(37 + 2*n_reads));
    repeat (3) @(negedge clk);
    check("done_single_pulse", 256'(done_cnt), 256'(1));
    check("error_flag", 256'(error), 256'(!succ));
    check("hash_out", hash_out, succ ? sha256_block(msg) : 256'd0);
    check("protocol_violations", 256'(proto_err), 256'(0));
    check("write_count", 256'(wr_addr_q.size()), 256'(18));
    for (int i = 0; i < 18 && i < wr_addr_q.size(); i++) begin
      ea = (i == 0 || i == 17) ? BASE : BASE + 32'h100 + 32'(4*(i-1));
      ed = (i == 0) ? 32'd1 : (i == 17) ? 32'd0 : msg[511 - 32*(i-1) -: 32];
      check("write_beat", 256'({wr_addr_q[i], wr_data_q[i]}), 256'({ea, ed}));
    end
    check("read_count", 256'(rd_addr_q.size()), 256'(n_reads));
    for (int i = 0; i < n_reads && i < rd_addr_q.size(); i++) begin
      ea = (i < n_ctrl) ? BASE : BASE + 32'h200 + 32'(4*(i - n_ctrl));
      check("read_addr", 256'(rd_addr_q[i]), 256'(ea));
    end
  endtask

  initial begin
    int cyc;
    logic [511:0] abc_msg;
    resetn = 1'b0;
    start  = 1'b0;
    msg_in = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl_outputs",
          256'({busy, done, error, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready}),
          256'(0));
    check("reset_hash_out", hash_out, 256'(0));
    resetn = 1'b1;
    @(negedge clk);

    abc_msg = {32'h61626380, 448'd0, 32'h00000018};
    check("model_abc_digest", sha256_block(abc_msg), ABC_DIGEST);
    run_job(abc_msg, 31, 0);
    check("abc_hash_out", hash_out, ABC_DIGEST);

    run_job(rand_msg(), 0, 0);
    run_job(rand_msg(), PLIM - 1, 0);
    run_job(rand_msg(), 1000, 0);
    run_job(rand_msg(), PLIM, 0);
    run_job(rand_msg(), 3, 0);

    stall_wr  = 5;
    stall_rsp = 7;
    run_job(abc_msg, $urandom_range(10, 0), 0);
    run_job(rand_msg(), $urandom_range(10, 0), 0);
    run_job(rand_msg(), $urandom_range(10, 0), 1);

    @(negedge clk);
    ready_after = 2;
    msg_in = rand_msg();
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (!(mem_axi_awvalid && mem_axi_awaddr == BASE + 32'h11C) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_msg_word7", 256'(cyc < 2000), 256'(1));
    resetn = 1'b0;
    #1;
    check("midjob_reset_outputs",
          256'({busy, done, error, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_rready}),
          256'(0));
    check("midjob_reset_hash", hash_out, 256'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_job(rand_msg(), 4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
